// File: rtl/ifft_pkg.sv
// Shared types and constants for the 8-point streaming inverse FFT:
// packed complex word, FSM states, twiddle table and bit-reversal helper.
package ifft_pkg;

  localparam int unsigned DW  = 17;
  localparam int unsigned TW  = 17;
  localparam int unsigned NPT = 8;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [TW-1:0] re;
    logic signed [TW-1:0] im;
  } twid_t;

  typedef enum logic [1:0] {LOAD, CALC, OUT} state_e;

  // exp(+j*2*pi*m/8), 32768 == +1.0
  localparam twid_t W0 = '{re:  17'sd32768, im: 17'sd0};
  localparam twid_t W1 = '{re:  17'sd23170, im: 17'sd23170};
  localparam twid_t W2 = '{re:  17'sd0,     im: 17'sd32768};
  localparam twid_t W3 = '{re: -17'sd23170, im: 17'sd23170};

  function automatic twid_t twiddle(input logic [1:0] m);
    case (m)
      2'd0:    return W0;
      2'd1:    return W1;
      2'd2:    return W2;
      default: return W3;
    endcase
  endfunction

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational radix-2 butterfly: t = (b*W)>>>15, outputs sat((a+t)>>>1)
// and sat((a-t)>>>1), with floor-truncating arithmetic shifts.
module ifft_bfly
  import ifft_pkg::*;
(
  input  cplx_t a_i,
  input  cplx_t b_i,
  input  twid_t w_i,
  output cplx_t p_o,
  output cplx_t q_o
);

  localparam int unsigned PW  = DW + TW;  // partial product width
  localparam int unsigned TSW = PW - 15;  // twiddled term width
  localparam int unsigned SW  = TSW + 1;  // add/sub width

  logic signed [PW-1:0]  br, bi, wr, wi;
  logic signed [PW-1:0]  prod_re, prod_im;
  logic signed [TSW-1:0] t_re, t_im;
  logic signed [SW-1:0]  sum_re, sum_im, dif_re, dif_im;

  // Any value outside the DW-bit range clamps to the nearest rail.
  function automatic logic signed [DW-1:0] sat(input logic [SW-2:0] x);
    if (x[SW-2:DW-1] == '0 || x[SW-2:DW-1] == '1) return x[DW-1:0];
    else if (x[SW-2])                             return {1'b1, {(DW-1){1'b0}}};
    else                                          return {1'b0, {(DW-1){1'b1}}};
  endfunction

  always_comb begin
    br      = PW'(b_i.re);
    bi      = PW'(b_i.im);
    wr      = PW'(w_i.re);
    wi      = PW'(w_i.im);
    prod_re = br * wr - bi * wi;
    prod_im = br * wi + bi * wr;
    t_re    = TSW'(prod_re >>> 15);
    t_im    = TSW'(prod_im >>> 15);
    sum_re  = SW'(a_i.re) + SW'(t_re);
    sum_im  = SW'(a_i.im) + SW'(t_im);
    dif_re  = SW'(a_i.re) - SW'(t_re);
    dif_im  = SW'(a_i.im) - SW'(t_im);
    p_o.re  = sat((SW-1)'(sum_re >>> 1));
    p_o.im  = sat((SW-1)'(sum_im >>> 1));
    q_o.re  = sat((SW-1)'(dif_re >>> 1));
    q_o.im  = sat((SW-1)'(dif_im >>> 1));
  end

endmodule

// File: rtl/ifft8_stream.sv
// Streaming 8-point radix-2 inverse FFT: loads bins in bit-reversed order,
// runs 12 in-place butterfly cycles, then streams time samples in order.
module ifft8_stream
  import ifft_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2*DW-1:0] data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*DW-1:0] data_out,
  output logic          out_last
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        in_ready_q, out_valid_q;
  logic        load_we, calc_we;

  cplx_t       mem_q [NPT];

  logic [1:0]  stage, bidx, tw_m;
  logic [2:0]  p_addr, q_addr;
  twid_t       tw;
  cplx_t       bf_p, bf_q;

  assign stage = cnt_q[3:2];
  assign bidx  = cnt_q[1:0];

  // Closed forms of p=((b>>s)<<(s+1))+(b&(h-1)), q=p+h, m=(b&(h-1))<<(2-s).
  always_comb begin
    p_addr = '0;
    q_addr = '0;
    tw_m   = '0;
    case (stage)
      2'd0: begin
        p_addr = {bidx, 1'b0};
        q_addr = {bidx, 1'b1};
      end
      2'd1: begin
        p_addr = {bidx[1], 1'b0, bidx[0]};
        q_addr = {bidx[1], 1'b1, bidx[0]};
        tw_m   = {bidx[0], 1'b0};
      end
      default: begin
        p_addr = {1'b0, bidx};
        q_addr = {1'b1, bidx};
        tw_m   = bidx;
      end
    endcase
  end

  assign tw = twiddle(tw_m);

  ifft_bfly u_bfly (
    .a_i (mem_q[p_addr]),
    .b_i (mem_q[q_addr]),
    .w_i (tw),
    .p_o (bf_p),
    .q_o (bf_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    load_we = 1'b0;
    calc_we = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          load_we = 1'b1;
          if (cnt_q == 4'd7) begin
            state_d = CALC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      CALC: begin
        calc_we = 1'b1;
        if (cnt_q == 4'd11) begin
          state_d = OUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      OUT: begin
        if (out_valid_q && out_ready) begin
          if (idx_q == 3'd7) begin
            state_d = LOAD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      in_ready_q  <= (state_d == LOAD);
      out_valid_q <= (state_d == OUT);
    end
  end

  // Sample buffer needs no reset: every location is rewritten on each LOAD.
  always_ff @(posedge clk) begin
    if (load_we) mem_q[bitrev3(cnt_q[2:0])] <= cplx_t'(data_in);
    if (calc_we) begin
      mem_q[p_addr] <= bf_p;
      mem_q[q_addr] <= bf_q;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = out_valid_q ? mem_q[idx_q] : '0;
  assign out_last  = out_valid_q && (idx_q == 3'd7);

endmodule

// File: tb/tb_ifft8_stream.sv
// Scoreboard bench for ifft8_stream: directed frames push expected samples,
// an independent monitor pops and compares each accepted output.
module tb_ifft8_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] data_out;
  logic        out_last;

  typedef struct {
    int re;
    int im;
    int tol;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int in_re [8];
  int in_im [8];
  int ex_re [8];
  int ex_im [8];

  bit          stall_prev = 1'b0;
  logic [33:0] held_data;
  logic        held_last;

  ifft8_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] pack(input int re, input int im);
    logic [31:0] r;
    logic [31:0] i;
    r = re;
    i = im;
    return {r[16:0], i[16:0]};
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  int'(in_ready),  0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_last"},  int'(out_last),  0);
    chk({tag, "_data_out"},  (data_out == 34'd0) ? 0 : 1, 0);
  endtask

  // Monitor: compares every accepted output and checks hold during stalls.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      exp_t e;
      int   are, aim, dre, dim;
      chk("in_ready_low_in_out", int'(in_ready), 0);
      if (stall_prev) begin
        total++;
        if (data_out !== held_data || out_last !== held_last) begin
          bad++;
          $display("FAIL stall_hold: got %h/%0b expected %h/%0b", data_out, out_last, held_data, held_last);
        end
      end
      if (out_ready) begin
        total++;
        are = int'($signed(data_out[33:17]));
        aim = int'($signed(data_out[16:0]));
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got (%0d,%0d) expected no output", are, aim);
        end else begin
          e   = sb.pop_front();
          dre = are - e.re;
          dim = aim - e.im;
          if (dre < 0) dre = -dre;
          if (dim < 0) dim = -dim;
          if (dre > e.tol || dim > e.tol || out_last !== e.last) begin
            bad++;
            $display("FAIL sample: got (%0d,%0d) last=%0b expected (%0d,%0d)+-%0d last=%0b",
                     are, aim, out_last, e.re, e.im, e.tol, e.last);
          end
        end
      end
      stall_prev = !out_ready;
      held_data  = data_out;
      held_last  = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic run_frame(input int tol, input bit gaps, input bit stall, input bit push);
    bit accepted;
    int tries;
    int n;
    if (push) begin
      for (int i = 0; i < 8; i++) begin
        exp_t e;
        e.re = ex_re[i]; e.im = ex_im[i]; e.tol = tol; e.last = (i == 7);
        sb.push_back(e);
      end
    end
    for (int k = 0; k < 8; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          data_in  = pack(-5, 5);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      data_in  = pack(in_re[k], in_im[k]);
      accepted = 1'b0;
      tries    = 0;
      while (!accepted && tries < 50) begin
        @(negedge clk);
        accepted = in_ready;
        @(posedge clk); #1;
        tries++;
      end
      if (!accepted) chk("accept_timeout", 0, 1);
    end
    // With gaps enabled, keep offering junk while the block is busy.
    in_valid = gaps;
    data_in  = pack(12345, -777);
    if (!push) return;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("calc_ready_valid_low", int'({in_ready, out_valid}), 0);
    end
    @(negedge clk);
    chk("first_out_latency", int'(out_valid), 1);
    @(posedge clk); #1;
    if (stall) begin
      n = 0;
      while (sb.size() > 5 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      out_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_drained", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_dc();
    in_re = '{8192, 0, 0, 0, 0, 0, 0, 0};
    in_im = '{0, 0, 0, 0, 0, 0, 0, 0};
    ex_re = '{1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024};
    ex_im = '{0, 0, 0, 0, 0, 0, 0, 0};
  endtask

  task automatic set_tone();
    in_re = '{0, 8192, 0, 0, 0, 0, 0, 0};
    in_im = '{0, 0, 0, 0, 0, 0, 0, 0};
    ex_re = '{1024, 724, 0, -724, -1024, -724, 0, 724};
    ex_im = '{0, 724, 1024, 724, 0, -724, -1024, -724};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b1;
    #12;
    check_reset("por");
    in_valid = 1'b1;
    data_in  = pack(999, 999);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("in_ready_before_edge", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", int'(in_ready), 1);

    set_dc();
    run_frame(0, 1'b0, 1'b0, 1'b1);

    in_re = '{1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024};
    in_im = '{0, 0, 0, 0, 0, 0, 0, 0};
    ex_re = '{1024, 0, 0, 0, 0, 0, 0, 0};
    ex_im = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(0, 1'b0, 1'b0, 1'b1);

    set_tone();
    run_frame(2, 1'b0, 1'b0, 1'b1);

    // Exact fixed-point result of the tone frame; stalls must not change it.
    set_tone();
    ex_re = '{1024, 724, 0, -725, -1024, -724, 0, 724};
    run_frame(0, 1'b1, 1'b1, 1'b1);

    in_re = '{65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535};
    in_im = '{-65536, -65536, -65536, -65536, -65536, -65536, -65536, -65536};
    ex_re = '{65535, 0, 0, 0, 0, 0, 0, 0};
    ex_im = '{-65536, 0, 0, 0, 0, 0, 0, 0};
    run_frame(2, 1'b0, 1'b0, 1'b1);

    set_tone();
    run_frame(0, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("mid_calc_rst");
    repeat (2) @(posedge clk);
    #1;
    check_reset("mid_calc_rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", int'(in_ready), 1);
    set_dc();
    run_frame(0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
